mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port unified memory between the instruction-fetch stage and the load/store (MEM) stage of the pipeline. It runs one transaction at a time with a request/grant/response handshake toward memory. It returns per-requester data with a one-cycle valid pulse and drives the `stall_if` / `stall_mem` pipeline-hold signals. Arbitration gives the LSU priority and bounds IF starvation with a counter.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (mask width is `DATA_W/8`)
- `STARVE_MAX`, 4, maximum consecutive LSU grants while IF waits
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch request; held with `if_addr` until `if_valid` or flush
- `if_addr` in ADDR_W: fetch address
- `if_flush` in 1: branch taken; discard the current or pending fetch
- `if_rdata` out DATA_W: fetched word, registered
- `if_valid` out 1: one-cycle pulse when `if_rdata` is valid
- `lsu_req` in 1: load/store request; held with its operands until `lsu_valid`
- `lsu_we` in 1: 1 = store
- `lsu_mask` in DATA_W/8: byte enables
- `lsu_addr` in ADDR_W: data address
- `lsu_wdata` in DATA_W: store data
- `lsu_rdata` out DATA_W: load data, registered
- `lsu_valid` out 1: one-cycle pulse on completion (load or store)
- `mem_req` out 1, `mem_we` out 1, `mem_mask` out DATA_W/8, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: registered memory request
- `mem_gnt` in 1: memory accepts the request this cycle
- `mem_rvalid` in 1: response (read data or write ack), one cycle
- `mem_rdata` in DATA_W: read data
- `stall_if` out 1: `if_req & ~if_valid & ~if_flush`
- `stall_mem` out 1: `lsu_req & ~lsu_valid`

## Operation
- **FSM states:** IDLE, REQ, RSP, DONE. An `owner` register (IF/LSU) and a `drop` flag accompany the FSM.
- **IDLE arbitration:** LSU wins if `lsu_req & (~if_req | if_flush | starve_cnt < STARVE_MAX)`. Otherwise IF wins if `if_req & ~if_flush`. If nothing wins, stay in IDLE.
- **On a win:** register `owner` and the winner's operands onto `mem_*`. For IF, `mem_we=0` and `mem_mask` is all ones. Set `mem_req=1` and go to REQ.
- **REQ:** hold `mem_*` stable until `mem_gnt`. On `mem_gnt`, clear `mem_req` and go to RSP.
- **RSP:** wait for `mem_rvalid`. On it, capture `mem_rdata` into the owner's rdata register and go to DONE.
- **DONE:** pulse the owner's valid for one cycle, unless `drop` is set. Then return to IDLE and clear `drop`.
- **`starve_cnt`:** increments (saturating at STARVE_MAX) on each LSU win while `if_req` is high. It clears on an IF win or when `if_req` is low at an LSU win.
- **Fetch flush:** `if_flush` high in REQ/RSP/DONE while owner=IF sets `drop`. The transaction still completes on the memory side; no `if_valid` is issued. Fetches cannot be cancelled once issued.
- **Protocol errors:** `mem_gnt` outside REQ and `mem_rvalid` outside RSP are ignored.
- **LSU transactions** are never dropped.

## Timing
- **Reset values:** state IDLE; `mem_req`, `mem_we`, `if_valid`, `lsu_valid`, `drop`, `starve_cnt` = 0; `mem_mask`/`mem_addr`/`mem_wdata`/`if_rdata`/`lsu_rdata` = 0. Stalls are forced to 0 while `rst_n` is low.
- **Minimum latency:** request seen in IDLE at cycle 0 → `mem_req` at 1 (gnt same cycle) → `mem_rvalid` at 2 → valid pulse at 3 → IDLE at 4. Each added gnt or rvalid wait cycle adds one.
- **Back-to-back:** the next arbitration happens in the IDLE cycle after DONE. The completed requester has already seen valid and may have a new request by then.
- **Stall timing:** `stall_*` is combinational and deasserts in the valid-pulse cycle, so the pipeline advances at that edge.
- **Reset mid-transaction:** the FSM aborts to IDLE immediately and no valid is issued. Memory shares `rst_n` and discards outstanding requests.
- **Simultaneous `lsu_req` and `if_req` in IDLE** are resolved by the arbitration rule above. A simultaneous `if_flush` removes IF from contention.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `arb_state_e` (IDLE, REQ, RSP, DONE)
  - `arb_owner_e` (OWN_IF, OWN_LSU)
  - default width constants
- No sub-module: the FSM, starvation counter and output registers stay in one module.

## Test plan
- **Single load:** `lsu_req`, addr 0x100, memory returns 0xDEADBEEF with 0-wait gnt and 1-cycle rvalid → `lsu_valid` and `lsu_rdata`=0xDEADBEEF at cycle 3; `stall_mem` high for cycles 0-2.
- **Contention:** `if_req` and `lsu_req` both at cycle 0 → LSU served first, then IF. `if_valid` arrives 4 cycles after `lsu_valid`.
- **Starvation:** `if_req` held while the LSU issues 6 back-to-back requests, STARVE_MAX=4 → the 5th grant goes to IF, after which the LSU resumes.
- **Flush:** IF transaction in RSP, `if_flush` pulses → no `if_valid`, FSM returns to IDLE, and the next fetch to addr 0x40 completes normally.
- **Wait states and store:** store with `mem_gnt` delayed 3 cycles → `mem_*` stable through REQ, `mem_we`=1 with correct mask, `lsu_valid` on the cycle after `mem_rvalid`.
- **Reset mid-RSP:** deassert `rst_n` during RSP → all outputs return to reset values immediately; no valid pulse after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/LSU unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the LSU.
// One transaction at a time; LSU has priority, IF starvation is bounded.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [DATA_W/8-1:0] lsu_mask,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);

  arb_state_e         state_q, state_d;
  arb_owner_e         owner_q, owner_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [MASK_W-1:0]  mem_mask_q, mem_mask_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  lsu_rdata_q, lsu_rdata_d;
  logic               if_valid_q, if_valid_d;
  logic               lsu_valid_q, lsu_valid_d;

  logic lsu_win_c;
  logic if_win_c;
  logic flush_hit_c;

  // IDLE arbitration: LSU first unless IF has waited through STARVE_MAX LSU grants
  assign lsu_win_c   = lsu_req & (~if_req | if_flush | (starve_cnt_q < CNT_W'(STARVE_MAX)));
  assign if_win_c    = ~lsu_win_c & if_req & ~if_flush;
  assign flush_hit_c = if_flush & (owner_q == OWN_IF);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (lsu_win_c | if_win_c) state_d = REQ;
      REQ:  if (mem_gnt)              state_d = RSP;
      RSP:  if (mem_rvalid)           state_d = DONE;
      DONE:                           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Output / datapath next values; a flushed fetch still finishes on the memory side
  always_comb begin
    owner_d      = owner_q;
    drop_d       = drop_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_mask_d   = mem_mask_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    if_valid_d   = 1'b0;
    lsu_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (lsu_win_c) begin
          owner_d     = OWN_LSU;
          mem_req_d   = 1'b1;
          mem_we_d    = lsu_we;
          mem_mask_d  = lsu_mask;
          mem_addr_d  = lsu_addr;
          mem_wdata_d = lsu_wdata;
          if (!if_req)                                starve_cnt_d = '0;
          else if (starve_cnt_q != CNT_W'(STARVE_MAX)) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else if (if_win_c) begin
          owner_d      = OWN_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_mask_d   = '1;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end
      end
      REQ: begin
        if (flush_hit_c) drop_d = 1'b1;
        if (mem_gnt)     mem_req_d = 1'b0;
      end
      RSP: begin
        if (flush_hit_c) drop_d = 1'b1;
        if (mem_rvalid) begin
          if (owner_q == OWN_LSU) begin
            lsu_rdata_d = mem_rdata;
            lsu_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = ~drop_q & ~if_flush;
          end
        end
      end
      DONE:    drop_d = 1'b0;
      default: drop_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWN_IF;
      drop_q       <= 1'b0;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_mask_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
      if_valid_q   <= 1'b0;
      lsu_valid_q  <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      drop_q       <= drop_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_mask_q   <= mem_mask_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
      if_valid_q   <= if_valid_d;
      lsu_valid_q  <= lsu_valid_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_mask  = mem_mask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign lsu_rdata = lsu_rdata_q;
  assign lsu_valid = lsu_valid_q;

  // Pipeline holds release in the valid-pulse cycle; forced low during reset
  assign stall_if  = rst_n & if_req & ~if_valid_q & ~if_flush;
  assign stall_mem = rst_n & lsu_req & ~lsu_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model plus completion scoreboard.
module tb_mem_arbiter;

  typedef struct packed {
    logic        is_lsu;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, lsu_req, lsu_we;
  logic [31:0] if_addr, lsu_addr, lsu_wdata;
  logic [3:0]  lsu_mask;
  logic [31:0] if_rdata, lsu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, lsu_valid, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_mask;
  logic        stall_if, stall_mem;

  int n_cmp = 0;
  int n_bad = 0;
  int gnt_wait = 0;
  int rv_wait = 0;
  exp_t sb_q[$];
  logic [31:0] mem_model [logic [31:0]];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_mask(lsu_mask),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_valid(lsu_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_default(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: gnt after gnt_wait cycles of mem_req, response rv_wait cycles later
  initial begin
    int ph;
    int cnt;
    logic        wr;
    logic [31:0] a, wd, cur;
    logic [3:0]  m;
    ph = 0; cnt = 0; wr = 1'b0; a = '0; wd = '0; m = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        ph = 0; cnt = 0;
      end else if (ph == 0) begin
        if (mem_req) begin
          if (cnt >= gnt_wait) begin
            mem_gnt = 1'b1;
            a = mem_addr; wr = mem_we; m = mem_mask; wd = mem_wdata;
            ph = 1; cnt = 0;
          end else cnt++;
        end
      end else begin
        if (cnt >= rv_wait) begin
          mem_rvalid = 1'b1;
          cur = mem_model.exists(a) ? mem_model[a] : rd_default(a);
          if (wr) begin
            for (int b = 0; b < 4; b++) if (m[b]) cur[8*b +: 8] = wd[8*b +: 8];
            mem_model[a] = cur;
            mem_rdata = '0;
          end else begin
            mem_rdata = cur;
          end
          ph = 0; cnt = 0;
        end else cnt++;
      end
    end
  end

  // Scoreboard: every valid pulse must match the next expected completion
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && (if_valid === 1'b1 || lsu_valid === 1'b1)) begin
        n_cmp++;
        if (if_valid === 1'b1 && lsu_valid === 1'b1) begin
          n_bad++;
          $display("FAIL sb_both_valid: got if_valid=1 lsu_valid=1, required at most one");
        end else if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got valid lsu=%0b rdata=%h, required no completion",
                   lsu_valid, lsu_valid ? lsu_rdata : if_rdata);
        end else begin
          e = sb_q.pop_front();
          if ({lsu_valid, (lsu_valid ? lsu_rdata : if_rdata)} !== {e.is_lsu, e.data}) begin
            n_bad++;
            $display("FAIL sb_data: got lsu=%0b data=%h, required lsu=%0b data=%h",
                     lsu_valid, lsu_valid ? lsu_rdata : if_rdata, e.is_lsu, e.data);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input bit lsu, input int max_cyc, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if (lsu ? (lsu_valid === 1'b1) : (if_valid === 1'b1)) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_mask = '0; lsu_addr = '0; lsu_wdata = '0;
    #2 rst_n = 1'b0;
    if_req = 1'b1; lsu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_mask, mem_addr, mem_wdata, if_valid, lsu_valid, if_rdata, lsu_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b we=%b mask=%h addr=%h wdata=%h iv=%b lv=%b ird=%h lrd=%h, required all 0",
               mem_req, mem_we, mem_mask, mem_addr, mem_wdata, if_valid, lsu_valid, if_rdata, lsu_rdata);
    end
    n_cmp++;
    if ({stall_if, stall_mem} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_stalls: got %b, required 00", {stall_if, stall_mem});
    end
    if_req = 1'b0; lsu_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single_load();
    @(posedge clk); #1;
    mem_model[32'h100] = 32'hDEADBEEF;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h100; lsu_mask = 4'hF; lsu_wdata = '0;
    sb_q.push_back('{1'b1, 32'hDEADBEEF});
    #1;
    n_cmp++;
    if (stall_mem !== 1'b1) begin
      n_bad++;
      $display("FAIL load_stall_c0: got %b, required 1", stall_mem);
    end
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        n_cmp++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
          n_bad++;
          $display("FAIL load_mem_req: got req=%b we=%b addr=%h, required 1 0 00000100", mem_req, mem_we, mem_addr);
        end
      end
      n_cmp++;
      if (c < 3 && {lsu_valid, stall_mem} !== 2'b01) begin
        n_bad++;
        $display("FAIL load_wait_c%0d: got valid/stall=%b, required 01", c, {lsu_valid, stall_mem});
      end else if (c == 3 && {lsu_valid, stall_mem, lsu_rdata} !== {2'b10, 32'hDEADBEEF}) begin
        n_bad++;
        $display("FAIL load_done_c3: got valid=%b stall=%b rdata=%h, required 1 0 deadbeef", lsu_valid, stall_mem, lsu_rdata);
      end
    end
    lsu_req = 1'b0;
  endtask

  task automatic test_contention();
    bit got;
    int cyc;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h40;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h200; lsu_mask = 4'hF;
    sb_q.push_back('{1'b1, rd_default(32'h200)});
    sb_q.push_back('{1'b0, rd_default(32'h40)});
    wait_valid(1'b1, 10, got, cyc);
    n_cmp++;
    if (!got || cyc != 3) begin
      n_bad++;
      $display("FAIL cont_lsu_first: got seen=%0b cycle=%0d, required seen=1 cycle=3", got, cyc);
    end
    lsu_req = 1'b0;
    #1;
    n_cmp++;
    if (stall_if !== 1'b1) begin
      n_bad++;
      $display("FAIL cont_if_stalled: got %b, required 1", stall_if);
    end
    wait_valid(1'b0, 10, got, cyc);
    n_cmp++;
    if (!got || cyc != 4) begin
      n_bad++;
      $display("FAIL cont_if_after: got seen=%0b cycles=%0d, required seen=1 cycles=4", got, cyc);
    end
    n_cmp++;
    if (stall_if !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_if_stall_release: got %b, required 0", stall_if);
    end
    if_req = 1'b0;
  endtask

  task automatic test_starvation();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) sb_q.push_back('{1'b1, rd_default(32'h300 + 32'(4 * i))});
    sb_q.push_back('{1'b0, rd_default(32'h80)});
    for (int i = 4; i < 6; i++) sb_q.push_back('{1'b1, rd_default(32'h300 + 32'(4 * i))});
    sb_q.push_back('{1'b0, rd_default(32'h84)});
    fork
      begin : lsu_drv
        bit got;
        int cyc;
        for (int i = 0; i < 6; i++) begin
          lsu_req = 1'b1; lsu_we = 1'b0; lsu_mask = 4'hF; lsu_addr = 32'h300 + 32'(4 * i);
          wait_valid(1'b1, 40, got, cyc);
          n_cmp++;
          if (!got) begin
            n_bad++;
            $display("FAIL starve_lsu_%0d: got no lsu_valid in 40 cycles, required completion", i);
            break;
          end
        end
        lsu_req = 1'b0;
      end
      begin : if_drv
        bit got;
        int cyc;
        if_req = 1'b1; if_addr = 32'h80;
        wait_valid(1'b0, 60, got, cyc);
        n_cmp++;
        if (!got) begin
          n_bad++;
          $display("FAIL starve_if_first: got no if_valid in 60 cycles, required completion");
        end
        if_addr = 32'h84;
        wait_valid(1'b0, 60, got, cyc);
        n_cmp++;
        if (!got) begin
          n_bad++;
          $display("FAIL starve_if_second: got no if_valid in 60 cycles, required completion");
        end
        if_req = 1'b0;
      end
    join
    @(posedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL starve_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_flush();
    bit got;
    int cyc;
    @(posedge clk); #1;
    rv_wait = 2;
    if_req = 1'b1; if_addr = 32'h60;
    sb_q.push_back('{1'b0, rd_default(32'h40)});
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_flush = 1'b1;
    #1;
    n_cmp++;
    if (stall_if !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_stall: got %b, required 0", stall_if);
    end
    @(posedge clk); #1;
    if_flush = 1'b0; if_addr = 32'h40;
    wait_valid(1'b0, 20, got, cyc);
    n_cmp++;
    if (!got || cyc != 8) begin
      n_bad++;
      $display("FAIL flush_refetch: got seen=%0b cycles=%0d, required seen=1 cycles=8", got, cyc);
    end
    n_cmp++;
    if (if_rdata !== rd_default(32'h40)) begin
      n_bad++;
      $display("FAIL flush_rdata: got %h, required %h", if_rdata, rd_default(32'h40));
    end
    if_req = 1'b0;
    rv_wait = 0;
  endtask

  task automatic test_store_wait();
    bit got;
    int cyc;
    @(posedge clk); #1;
    gnt_wait = 3;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_mask = 4'b0101; lsu_addr = 32'h140; lsu_wdata = 32'h11223344;
    sb_q.push_back('{1'b1, 32'h0});
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (c <= 4 && {mem_req, mem_we, mem_mask, mem_addr, mem_wdata, lsu_valid, stall_mem} !==
                    {1'b1, 1'b1, 4'b0101, 32'h140, 32'h11223344, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL store_hold_c%0d: got req=%b we=%b mask=%b addr=%h wdata=%h lv=%b, required 1 1 0101 00000140 11223344 0",
                 c, mem_req, mem_we, mem_mask, mem_addr, mem_wdata, lsu_valid);
      end else if (c == 5 && {mem_req, lsu_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL store_rsp_c5: got req=%b valid=%b, required 0 0", mem_req, lsu_valid);
      end else if (c == 6 && {lsu_valid, stall_mem} !== 2'b10) begin
        n_bad++;
        $display("FAIL store_done_c6: got valid=%b stall=%b, required 1 0", lsu_valid, stall_mem);
      end
    end
    gnt_wait = 0;
    lsu_we = 1'b0; lsu_wdata = '0;
    sb_q.push_back('{1'b1, 32'h0122FE44});
    wait_valid(1'b1, 10, got, cyc);
    n_cmp++;
    if (!got || cyc != 4 || lsu_rdata !== 32'h0122FE44) begin
      n_bad++;
      $display("FAIL store_readback: got seen=%0b cycles=%0d rdata=%h, required 1 4 0122fe44", got, cyc, lsu_rdata);
    end
    lsu_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got;
    int cyc;
    @(posedge clk); #1;
    rv_wait = 3;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h180; lsu_mask = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_mask, mem_addr, mem_wdata, if_valid, lsu_valid, if_rdata, lsu_rdata} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got req=%b addr=%h ird=%h lrd=%h, required all 0",
               mem_req, mem_addr, if_rdata, lsu_rdata);
    end
    n_cmp++;
    if (stall_mem !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_stall: got %b, required 0", stall_mem);
    end
    lsu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rv_wait = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({if_valid, lsu_valid, mem_req} !== 3'b000) begin
        n_bad++;
        $display("FAIL midreset_quiet_%0d: got iv/lv/req=%b, required 000", c, {if_valid, lsu_valid, mem_req});
      end
    end
    if_req = 1'b1; if_addr = 32'h44;
    sb_q.push_back('{1'b0, rd_default(32'h44)});
    wait_valid(1'b0, 10, got, cyc);
    n_cmp++;
    if (!got || cyc != 3) begin
      n_bad++;
      $display("FAIL midreset_recover: got seen=%0b cycles=%0d, required 1 3", got, cyc);
    end
    if_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_starvation();
    test_flush();
    test_store_wait();
    test_reset_mid();
    @(posedge clk); #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: got %0d pending, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
